sw_clk_mode_ctrl: RTL and testbench
===================================

# sw_clk_mode_ctrl

- Control sequencer for the stopwatch/clock display design.
- Sits between the raw front-panel buttons and the time-keeping counters. It drives those counters; it does not contain them.
- Functions:
  - synchronizes the buttons and converts them to edges;
  - tracks clock vs stopwatch mode and the stopwatch run/hold state;
  - generates the 1 Hz clock-tick and stopwatch-tick enables;
  - issues set pulses with auto-repeat on held buttons.
- Guarantee to the datapath: at most one of o_clk_tick / o_inc_* is asserted in any cycle.

## Interface
- TICK_DIV, 100_000_000: clk cycles per o_clk_tick.
- SW_DIV, 1_000_000: clk cycles per o_sw_tick (100 Hz at 100 MHz).
- REPEAT_DLY, 50_000_000: held cycles before the first auto-repeat.
- REPEAT_PER, 12_500_000: cycles between auto-repeat pulses.
- SYNC_STAGES, 2: synchronizer depth, ≥2.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. Asynchronous, active-low.
- i_add_sec, i_add_min, i_add_hr  in  1 each  debounced, asynchronous set buttons.
- i_Sw_Clk  in  1  mode-toggle button.
- i_Start_Stop  in  1  stopwatch start/stop button.
- i_reset  in  1  stopwatch clear button.
- o_mode  out  1  0 = clock, 1 = stopwatch (display select).
- o_clk_tick  out  1  one-cycle seconds enable for the clock counters.
- o_inc_sec, o_inc_min, o_inc_hr  out  1 each  one-cycle set pulses.
- o_sw_tick  out  1  one-cycle stopwatch enable.
- o_sw_clr  out  1  one-cycle stopwatch counter clear.
- o_running  out  1  stopwatch is in RUN.
- o_sw_state  out  2  00 STOP, 01 RUN, 10 HOLD.

## Operation
**Reset.** While rst = 0, all outputs are 0 and the synchronizers, prescalers and repeat counters are zeroed. o_mode = 0 and the stopwatch state is STOP.

**Input conditioning.** Each button passes through SYNC_STAGES flops, then a rising-edge detector.

**Mode toggle.**
- An i_Sw_Clk edge toggles o_mode.
- The stopwatch state is unaffected, so the stopwatch keeps running in the background.

**Stopwatch FSM** (buttons act only when o_mode = 1):
- STOP, Start_Stop → RUN.
- RUN, Start_Stop → HOLD.
- HOLD, Start_Stop → RUN.
- HOLD, reset → STOP, with o_sw_clr.
- STOP, reset → STOP, with o_sw_clr.
- RUN, reset → stays in RUN, with o_sw_clr; the SW prescaler is zeroed.
- Same-cycle Start_Stop and reset: reset wins. From RUN the FSM stays in RUN with o_sw_clr; from HOLD or STOP it goes to STOP with o_sw_clr; Start_Stop is dropped.

**SW prescaler.**
- Counts 0..SW_DIV-1 only in RUN; o_sw_tick fires at the terminal count.
- Frozen in HOLD, so the fractional count is preserved on resume.
- Zeroed together with o_sw_clr.

**Clock prescaler.**
- Free-running 0..TICK_DIV-1, in both modes; terminal count produces a tick.
- Counter width is $clog2(TICK_DIV).

**Set pulses** (only when o_mode = 0):
- A button edge gives an immediate o_inc_* pulse.
- While the button is held: next pulse after REPEAT_DLY cycles, then one every REPEAT_PER cycles.
- Release, or entering stopwatch mode, clears that button's repeat counter.
- Simultaneous candidates: priority sec > min > hr. Losers are dropped, not queued.

**Tick/set collision.**
- A clock tick coinciding with any o_inc_* is deferred one cycle through a pending flag.
- The clock prescaler itself is not disturbed.
- A pending tick always issues before the next one could fire, so no ticks are lost.

## Timing
- Button latency: raw input first sampled high at edge N → pulse during the cycle after edge N+SYNC_STAGES, exactly 1 cycle wide. Same latency for mode and FSM updates.
- o_clk_tick: first tick TICK_DIV cycles after rst deasserts, then period TICK_DIV (jitter +1 only on a deferral).
- o_sw_tick: first tick SW_DIV cycles after entering RUN from STOP, or after o_sw_clr in RUN.
- o_sw_clr: asserted in the same cycle as the FSM transition.
- rst asserted mid-operation: all state clears immediately (asynchronous). Release is synchronous to clk, through the usual reset-release path.

## Test plan
Parameters for all scenarios: TICK_DIV=10, SW_DIV=4, REPEAT_DLY=8, REPEAT_PER=3, SYNC_STAGES=2.

1. **Reset and free-run.** Pulse rst low, then release → all outputs 0, o_mode=0, o_sw_state=00; o_clk_tick on cycles 10, 20, 30 after release.
2. **Stopwatch sequence.** Sw_Clk, Start_Stop, wait 9 cycles, Start_Stop, reset →
   - o_mode=1;
   - RUN with o_sw_tick at +4 and +8;
   - HOLD, no ticks;
   - o_sw_clr for 1 cycle, then STOP.
3. **Auto-repeat.** In clock mode, hold i_add_min for 20 cycles → o_inc_min at edge+0, +8, +11, +14, +17; no pulse after release.
4. **Collision.** Press i_add_sec so that o_inc_sec lands on the clock terminal-count cycle → o_clk_tick appears the next cycle; the next tick stays on the original 10-cycle grid.
5. **Background run and ignored buttons.**
   - Start the stopwatch, then toggle to clock mode → o_sw_tick continues.
   - Press i_reset/Start_Stop in clock mode → ignored.
   - Press i_add_hr in stopwatch mode → no pulse.
6. **Simultaneous buttons.**
   - Same-cycle sec+min+hr → only o_inc_sec.
   - Same-cycle Start_Stop+reset in RUN → o_sw_clr, stays in RUN.

Source files
------------

// File: rtl/sw_clk_mode_ctrl_if.sv
// Front-panel button and counter-control bundle for sw_clk_mode_ctrl.
// master = panel/testbench side, slave = control sequencer side.
interface sw_clk_mode_ctrl_if;
   logic       i_add_sec;
   logic       i_add_min;
   logic       i_add_hr;
   logic       i_Sw_Clk;
   logic       i_Start_Stop;
   logic       i_reset;
   logic       o_mode;
   logic       o_clk_tick;
   logic       o_inc_sec;
   logic       o_inc_min;
   logic       o_inc_hr;
   logic       o_sw_tick;
   logic       o_sw_clr;
   logic       o_running;
   logic [1:0] o_sw_state;

   modport master (
      output i_add_sec, i_add_min, i_add_hr,
      output i_Sw_Clk, i_Start_Stop, i_reset,
      input  o_mode, o_clk_tick,
      input  o_inc_sec, o_inc_min, o_inc_hr,
      input  o_sw_tick, o_sw_clr,
      input  o_running, o_sw_state
   );

   modport slave (
      input  i_add_sec, i_add_min, i_add_hr,
      input  i_Sw_Clk, i_Start_Stop, i_reset,
      output o_mode, o_clk_tick,
      output o_inc_sec, o_inc_min, o_inc_hr,
      output o_sw_tick, o_sw_clr,
      output o_running, o_sw_state
   );
endinterface

// File: rtl/sw_clk_mode_ctrl.sv
// Stopwatch/clock control sequencer: button conditioning, mode and
// stopwatch FSM, tick prescalers and auto-repeating set pulses.
module sw_clk_mode_ctrl #(
   parameter int TICK_DIV    = 100_000_000,
   parameter int SW_DIV      = 1_000_000,
   parameter int REPEAT_DLY  = 50_000_000,
   parameter int REPEAT_PER  = 12_500_000,
   parameter int SYNC_STAGES = 2
) (
   input logic               clk,
   input logic               rst,
   sw_clk_mode_ctrl_if.slave bus
);
   localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SWW  = (SW_DIV > 1) ? $clog2(SW_DIV) : 1;
   localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SWW-1:0] SW_LAST   = SWW'(SW_DIV - 1);
   localparam logic [RW-1:0]  DLY_LAST  = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0]  PER_LAST  = RW'(REPEAT_PER - 1);

   localparam logic [1:0] ST_STOP = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_HOLD = 2'b10;

   localparam int B_MODE = 3;
   localparam int B_SS   = 4;
   localparam int B_CLR  = 5;

   logic [5:0]     raw;
   logic [5:0]     sync_q [SYNC_STAGES];
   logic [5:0]     prev_q;
   logic [5:0]     lvl;
   logic [5:0]     btn_edge;
   logic           mode_q;
   logic [1:0]     state_q;
   logic [1:0]     state_d;
   logic           clr_d;
   logic           clr_q;
   logic           running;
   logic [SWW-1:0] sw_cnt;
   logic           sw_tick_q;
   logic [TW-1:0]  tick_cnt;
   logic           tick_q;
   logic           pend_q;
   logic           due;
   logic [RW-1:0]  rep_cnt [3];
   logic [2:0]     rep_ph;
   logic [2:0]     rep_hit;
   logic [2:0]     cand;
   logic [2:0]     inc_d;
   logic [2:0]     inc_q;
   logic           any_inc;

   assign raw = {bus.i_reset, bus.i_Start_Stop, bus.i_Sw_Clk,
                 bus.i_add_hr, bus.i_add_min, bus.i_add_sec};
   assign lvl      = sync_q[SYNC_STAGES-1];
   assign btn_edge = lvl & ~prev_q;
   assign running  = (state_q == ST_RUN);

   // button synchronizer chain and edge-detect history
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= raw;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= lvl;
      end
   end

   // stopwatch FSM next state; clear beats start/stop, RUN survives a clear
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      if (mode_q && btn_edge[B_CLR]) begin
         clr_d   = 1'b1;
         state_d = running ? ST_RUN : ST_STOP;
      end else if (mode_q && btn_edge[B_SS]) begin
         case (state_q)
            ST_STOP: state_d = ST_RUN;
            ST_RUN:  state_d = ST_HOLD;
            ST_HOLD: state_d = ST_RUN;
            default: state_d = ST_STOP;
         endcase
      end
   end

   // set-pulse candidates: edge or repeat terminal, priority sec > min > hr
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         rep_hit[i] = (rep_cnt[i] == (rep_ph[i] ? PER_LAST : DLY_LAST));
         cand[i]    = !mode_q && (btn_edge[i] || (lvl[i] && rep_hit[i]));
      end
      inc_d[0] = cand[0];
      inc_d[1] = cand[1] & ~cand[0];
      inc_d[2] = cand[2] & ~(|cand[1:0]);
      any_inc  = |cand;
      due      = (tick_cnt == TICK_LAST) | pend_q;
   end

   // auto-repeat counters, held only while the button stays down in clock mode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) rep_cnt[i] <= '0;
         rep_ph <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (mode_q || !lvl[i] || btn_edge[i]) begin
               rep_cnt[i] <= '0;
               rep_ph[i]  <= 1'b0;
            end else if (rep_hit[i]) begin
               rep_cnt[i] <= '0;
               rep_ph[i]  <= 1'b1;
            end else begin
               rep_cnt[i] <= rep_cnt[i] + 1'b1;
            end
         end
      end
   end

   // mode, FSM state and registered set/clear pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q  <= 1'b0;
         state_q <= ST_STOP;
         clr_q   <= 1'b0;
         inc_q   <= '0;
      end else begin
         mode_q  <= mode_q ^ btn_edge[B_MODE];
         state_q <= state_d;
         clr_q   <= clr_d;
         inc_q   <= inc_d;
      end
   end

   // stopwatch prescaler: counts only in RUN, zeroed by a clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_cnt    <= '0;
         sw_tick_q <= 1'b0;
      end else begin
         sw_tick_q <= running && (sw_cnt == SW_LAST) && !clr_d;
         if (clr_d) sw_cnt <= '0;
         else if (running) sw_cnt <= (sw_cnt == SW_LAST) ? '0 : sw_cnt + 1'b1;
      end
   end

   // free-running seconds prescaler; a tick colliding with a set pulse waits a cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
         tick_q   <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
         tick_q   <= due & ~any_inc;
         pend_q   <= due & any_inc;
      end
   end

   assign bus.o_mode     = mode_q;
   assign bus.o_clk_tick = tick_q;
   assign bus.o_inc_sec  = inc_q[0];
   assign bus.o_inc_min  = inc_q[1];
   assign bus.o_inc_hr   = inc_q[2];
   assign bus.o_sw_tick  = sw_tick_q;
   assign bus.o_sw_clr   = clr_q;
   assign bus.o_running  = running;
   assign bus.o_sw_state = state_q;
endmodule

// File: tb/tb_sw_clk_mode_ctrl.sv
// Bench for sw_clk_mode_ctrl: pulse scoreboard keyed by cycle number
// plus a small seconds-tick model with collision deferral.
module tb_sw_clk_mode_ctrl;
   localparam logic [5:0] SEC  = 6'h01;
   localparam logic [5:0] MIN  = 6'h02;
   localparam logic [5:0] HR   = 6'h04;
   localparam logic [5:0] MODE = 6'h08;
   localparam logic [5:0] SS   = 6'h10;
   localparam logic [5:0] CLR  = 6'h20;

   localparam logic [5:0] P_SEC = 6'h01;
   localparam logic [5:0] P_MIN = 6'h02;
   localparam logic [5:0] P_SWT = 6'h08;
   localparam logic [5:0] P_CLR = 6'h10;

   typedef struct {
      int         cyc;
      logic [5:0] m;
   } ev_t;

   logic clk;
   logic rst;
   int   cyc;
   int   rel;
   bit   mon_en;
   int   checks;
   int   errors;
   ev_t  sbq[$];

   sw_clk_mode_ctrl_if bus ();

   sw_clk_mode_ctrl #(
      .TICK_DIV(10), .SW_DIV(4), .REPEAT_DLY(8),
      .REPEAT_PER(3), .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d act=%0h exp=%0h", tag, cyc, act, exp);
      end
   endtask

   task automatic sb_push(input int c, input logic [5:0] m);
      int  i;
      ev_t e;
      i = 0;
      while (i < sbq.size() && sbq[i].cyc < c) i++;
      if (i < sbq.size() && sbq[i].cyc == c) begin
         sbq[i].m = sbq[i].m | m;
      end else begin
         e.cyc = c;
         e.m   = m;
         sbq.insert(i, e);
      end
   endtask

   task automatic set_btn(input logic [5:0] m);
      bus.i_add_sec    = m[0];
      bus.i_add_min    = m[1];
      bus.i_add_hr     = m[2];
      bus.i_Sw_Clk     = m[3];
      bus.i_Start_Stop = m[4];
      bus.i_reset      = m[5];
   endtask

   task automatic press(input logic [5:0] m, input int hold);
      set_btn(m);
      repeat (hold) @(negedge clk);
      set_btn(6'h00);
   endtask

   task automatic at_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   function automatic logic [9:0] outs();
      return {bus.o_mode, bus.o_clk_tick, bus.o_inc_sec, bus.o_inc_min,
              bus.o_inc_hr, bus.o_sw_tick, bus.o_sw_clr, bus.o_running,
              bus.o_sw_state};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   // pulse monitor: scoreboard events plus modelled seconds ticks
   initial begin
      logic [5:0] em;
      logic [5:0] am;
      ev_t        ev;
      logic       due;
      logic       pend;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            pend = 1'b0;
         end else begin
            em = '0;
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
               ev = sbq.pop_front();
               if (ev.cyc < cyc) chk("sb_late", 32'(ev.cyc), 32'(cyc));
               else em = em | ev.m;
            end
            due   = (cyc > rel && ((cyc - rel) % 10) == 0) || pend;
            em[5] = due && (em[2:0] == 3'b000);
            pend  = due && (em[2:0] != 3'b000);
            am = {bus.o_clk_tick, bus.o_sw_clr, bus.o_sw_tick,
                  bus.o_inc_hr, bus.o_inc_min, bus.o_inc_sec};
            if ((am | em) != 6'h00) chk("pulse", 32'(am), 32'(em));
         end
      end
   end

   initial begin
      int b;
      int g;
      int k;
      int s;
      int n;
      int dl[5];
      checks = 0;
      errors = 0;
      mon_en = 1'b0;
      rel    = 0;
      rst    = 1'b0;
      set_btn(6'h00);
      dl = '{0, 8, 11, 14, 17};

      // reset and free-run
      repeat (3) @(negedge clk);
      chk("rst_outs", 32'(outs()), 32'h0);
      rst    = 1'b1;
      rel    = cyc;
      mon_en = 1'b1;
      at_cyc(rel + 35);
      chk("t1_mode", 32'(bus.o_mode), 32'h0);
      chk("t1_state", 32'(bus.o_sw_state), 32'h0);

      // stopwatch sequence
      b = cyc;
      press(MODE, 1);
      at_cyc(b + 3);
      chk("t2_mode", 32'(bus.o_mode), 32'h1);
      at_cyc(b + 6);
      sb_push(b + 13, P_SWT);
      sb_push(b + 17, P_SWT);
      sb_push(b + 25, P_CLR);
      press(SS, 1);
      at_cyc(b + 10);
      chk("t2_run", 32'(bus.o_sw_state), 32'h1);
      chk("t2_running", 32'(bus.o_running), 32'h1);
      at_cyc(b + 15);
      press(SS, 1);
      at_cyc(b + 19);
      chk("t2_hold", 32'(bus.o_sw_state), 32'h2);
      chk("t2_hold_run", 32'(bus.o_running), 32'h0);
      at_cyc(b + 22);
      press(CLR, 1);
      at_cyc(b + 26);
      chk("t2_stop", 32'(bus.o_sw_state), 32'h0);
      at_cyc(b + 27);
      press(MODE, 1);
      at_cyc(b + 31);
      chk("t2_clkmode", 32'(bus.o_mode), 32'h0);

      // auto-repeat on held minute button
      b = cyc;
      foreach (dl[i]) sb_push(b + 3 + dl[i], P_MIN);
      press(MIN, 20);
      at_cyc(b + 40);

      // set pulse landing on the seconds terminal count
      n = 0;
      while (((cyc + 3 - rel) % 10) != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      g = cyc + 3;
      sb_push(g, P_SEC);
      press(SEC, 1);
      at_cyc(g);
      chk("col_inc", 32'(bus.o_inc_sec), 32'h1);
      chk("col_tick_tc", 32'(bus.o_clk_tick), 32'h0);
      at_cyc(g + 1);
      chk("col_tick_late", 32'(bus.o_clk_tick), 32'h1);
      at_cyc(g + 10);
      chk("col_grid", 32'(bus.o_clk_tick), 32'h1);
      at_cyc(g + 15);

      // simultaneous set buttons
      k = cyc;
      sb_push(k + 3, P_SEC);
      press(SEC | MIN | HR, 1);
      at_cyc(k + 3);
      chk("t6_min", 32'(bus.o_inc_min), 32'h0);
      chk("t6_hr", 32'(bus.o_inc_hr), 32'h0);
      at_cyc(k + 15);

      // background run, ignored buttons, simultaneous start/stop + clear
      s = cyc;
      for (int t = s + 10; t <= s + 30; t += 4) sb_push(t, P_SWT);
      sb_push(s + 33, P_CLR);
      sb_push(s + 37, P_SWT);
      sb_push(s + 41, P_SWT);
      sb_push(s + 45, P_SWT);
      press(MODE, 1);
      at_cyc(s + 3);
      press(SS, 1);
      at_cyc(s + 8);
      press(MODE, 1);
      at_cyc(s + 12);
      press(CLR, 1);
      at_cyc(s + 14);
      press(SS, 1);
      at_cyc(s + 20);
      chk("t5_mode", 32'(bus.o_mode), 32'h0);
      chk("t5_state", 32'(bus.o_sw_state), 32'h1);
      press(MODE, 1);
      at_cyc(s + 24);
      press(HR, 1);
      at_cyc(s + 30);
      press(SS | CLR, 1);
      at_cyc(s + 34);
      chk("t6_run", 32'(bus.o_sw_state), 32'h1);
      chk("t6_mode", 32'(bus.o_mode), 32'h1);
      at_cyc(s + 47);
      chk("sb_empty", 32'(sbq.size()), 32'h0);

      // asynchronous reset mid-run
      mon_en = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst", 32'(outs()), 32'h0);
      sbq.delete();
      repeat (2) @(negedge clk);
      rst    = 1'b1;
      rel    = cyc;
      mon_en = 1'b1;
      at_cyc(rel + 12);
      chk("rr_mode", 32'(bus.o_mode), 32'h0);
      chk("rr_state", 32'(bus.o_sw_state), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
